// File: rtl/cpu4_nibble_ram.sv
`default_nettype none
// ============================================================================
// Module   : cpu4_nibble_ram
// Brief    : 64 x 4-bit program/data memory for the 4-bit accumulator CPU.
//            Combinational reads. Store addresses are recovered from the
//            two nibbles read just before a write cycle. A sequential loader
//            fills the memory after reset and holds the CPU in reset until
//            loading ends.
//            Optional feature macro: CPU4_RAM_WPROT_EN (drops RUN-state
//            stores to addresses 0..WPROT_TOP and pulses wprot_err).
// Revision : 1.0 - initial release
// ============================================================================
module cpu4_nibble_ram #(
  parameter int DEPTH     = 64,
  parameter int WPROT_TOP = 31
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic [5:0] cpu_addr,
  input  logic       cpu_wcyc,
  output logic [3:0] cpu_data,
  output logic       cpu_hold,
  input  logic       ld_valid,
  input  logic [3:0] ld_data,
  input  logic       ld_skip,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       wprot_err
);

  localparam logic [0:0] c_st_load = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam logic [5:0] c_ptr_last  = 6'(DEPTH - 1);
  localparam logic [5:0] c_wprot_top = 6'(WPROT_TOP);
`ifdef CPU4_RAM_WPROT_EN
  localparam logic c_wprot_en = 1'b1;
`else
  localparam logic c_wprot_en = 1'b0;
`endif

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [3:0] r_mem [DEPTH];
  logic [5:0] r_ptr;
  // Only the two low bits of the older nibble form the store address,
  // so only those bits of h_hi are kept.
  logic [1:0] r_h_hi;
  logic [3:0] r_h_lo;
  logic       r_wprot_err;

  logic       w_run;
  logic       w_ld_accept;
  logic       w_store;
  logic [5:0] w_st_addr;
  logic       w_st_drop;
  logic       w_we;
  logic [5:0] w_waddr;
  logic [3:0] w_wdata;

  assign w_run       = (r_state == c_st_run);
  assign w_ld_accept = !w_run && ld_valid;
  assign w_store     = w_run && cpu_wcyc;
  assign w_st_addr   = {r_h_hi, r_h_lo};
  assign w_st_drop   = c_wprot_en && (w_st_addr <= c_wprot_top);

  // Single write port shared by the loader (LOAD) and CPU stores (RUN).
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = ld_data;
    if (w_ld_accept) begin
      w_we = 1'b1;
    end else if (w_store && !w_st_drop) begin
      w_we    = 1'b1;
      w_waddr = w_st_addr;
      w_wdata = cpu_addr[3:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) r_state <= c_st_load;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave LOAD on skip or on accepting the last cell; RUN is sticky.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_st_load) begin
      if (ld_skip || (w_ld_accept && (r_ptr == c_ptr_last))) begin
        w_state_nxt = c_st_run;
      end
    end
  end

  // State-decoded outputs; read data is muted outside RUN and during writes.
  always_comb begin
    ld_ready = 1'b1;
    cpu_hold = 1'b1;
    ld_done  = 1'b0;
    cpu_data = 4'h0;
    if (w_run) begin
      ld_ready = 1'b0;
      cpu_hold = 1'b0;
      ld_done  = 1'b1;
      if (!cpu_wcyc) cpu_data = r_mem[cpu_addr];
    end
  end

  assign wprot_err = r_wprot_err;

  // Memory array: cleared by reset, written through the shared port.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 4'h0;
    end else if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Loader pointer advances on each accepted nibble and wraps after the last.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p)            r_ptr <= 6'd0;
    else if (w_ld_accept) r_ptr <= r_ptr + 6'd1;
  end

  // Snoop the last two read nibbles; frozen during write cycles.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_h_hi <= 2'd0;
      r_h_lo <= 4'h0;
    end else if (w_run && !cpu_wcyc) begin
      r_h_hi <= r_h_lo[1:0];
      r_h_lo <= cpu_data;
    end
  end

  // One-cycle flag for a store dropped by write protection.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) r_wprot_err <= 1'b0;
    else       r_wprot_err <= w_store && w_st_drop;
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu4_nibble_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu4_nibble_ram
// Brief    : Directed self-checking bench for cpu4_nibble_ram.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu4_nibble_ram;

  logic       clk = 1'b0;
  logic       rst_p;
  logic [5:0] cpu_addr;
  logic       cpu_wcyc;
  logic [3:0] cpu_data;
  logic       cpu_hold;
  logic       ld_valid;
  logic [3:0] ld_data;
  logic       ld_skip;
  logic       ld_ready;
  logic       ld_done;
  logic       wprot_err;

  int n_checks = 0;
  int n_fail   = 0;

  cpu4_nibble_ram #(.DEPTH(64), .WPROT_TOP(31)) dut (
    .clk       (clk),
    .rst_p     (rst_p),
    .cpu_addr  (cpu_addr),
    .cpu_wcyc  (cpu_wcyc),
    .cpu_data  (cpu_data),
    .cpu_hold  (cpu_hold),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_skip   (ld_skip),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .wprot_err (wprot_err)
  );

  always #5 clk = ~clk;

`ifdef CPU4_RAM_WPROT_EN
  localparam logic       c_prot    = 1'b1;
`else
  localparam logic       c_prot    = 1'b0;
`endif

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [5:0] a, input logic [3:0] exp);
    cpu_addr = a;
    cpu_wcyc = 1'b0;
    #1;
    check(tag, {4'h0, cpu_data}, {4'h0, exp});
  endtask

  task automatic pulse_reset();
    cpu_wcyc = 1'b0;
    ld_valid = 1'b0;
    ld_skip  = 1'b0;
    rst_p    = 1'b1;
    #1;
    rst_p    = 1'b0;
  endtask

  initial begin
    int k;
    rst_p    = 1'b1;
    cpu_addr = 6'd0;
    cpu_wcyc = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 4'h0;
    ld_skip  = 1'b0;
    #3;
    check("rst_ld_ready", {7'd0, ld_ready}, 8'd1);
    check("rst_cpu_hold", {7'd0, cpu_hold}, 8'd1);
    check("rst_ld_done", {7'd0, ld_done}, 8'd0);
    check("rst_cpu_data", {4'h0, cpu_data}, 8'h0);
    check("rst_wprot_err", {7'd0, wprot_err}, 8'd0);
    step();
    step();
    rst_p = 1'b0;

    // Skip straight to RUN: every cell reads 0.
    ld_skip = 1'b1;
    step();
    ld_skip = 1'b0;
    check("skip_ld_done", {7'd0, ld_done}, 8'd1);
    read_check("skip_rd15", 6'h15, 4'h0);
    read_check("skip_rd3f", 6'h3F, 4'h0);
    pulse_reset();
    check("rst2_ld_done", {7'd0, ld_done}, 8'd0);
    check("rst2_cpu_hold", {7'd0, cpu_hold}, 8'd1);
    step();

    // Full load: cell i holds i[3:0].
    ld_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ld_data = 4'(i);
      if (i == 63) begin
        check("ld63_done", {7'd0, ld_done}, 8'd0);
        check("ld63_hold", {7'd0, cpu_hold}, 8'd1);
        check("ld63_ready", {7'd0, ld_ready}, 8'd1);
      end
      step();
    end
    ld_valid = 1'b0;
    check("full_ld_done", {7'd0, ld_done}, 8'd1);
    check("full_cpu_hold", {7'd0, cpu_hold}, 8'd0);
    check("full_ld_ready", {7'd0, ld_ready}, 8'd0);
    read_check("full_rd25", 6'h25, 4'h5);
    read_check("full_rd3f", 6'h3F, 4'hF);

    // Snooped store: read 0x2 then 0xA -> address 0x2A, write 0x7.
    read_check("snp_rd02", 6'h02, 4'h2);
    step();
    read_check("snp_rd0a", 6'h0A, 4'hA);
    step();
    cpu_wcyc = 1'b1;
    cpu_addr = 6'h07;
    #1;
    check("wcyc_data0", {4'h0, cpu_data}, 8'h0);
    step();
    read_check("st_rd2a", 6'h2A, 4'h7);
    check("st_no_err", {7'd0, wprot_err}, 8'd0);
    step();

    // Back-to-back write cycles reuse the frozen address; last data wins.
    read_check("b2b_rd02", 6'h02, 4'h2);
    step();
    read_check("b2b_rd0a", 6'h0A, 4'hA);
    step();
    cpu_wcyc = 1'b1;
    cpu_addr = 6'h03;
    step();
    cpu_addr = 6'h09;
    step();
    read_check("b2b_rd2a", 6'h2A, 4'h9);
    step();

    // Store to 0x0A: dropped only when write protection is built in.
    read_check("wp_rd00", 6'h00, 4'h0);
    step();
    read_check("wp_rd0a", 6'h0A, 4'hA);
    step();
    cpu_wcyc = 1'b1;
    cpu_addr = 6'h05;
    step();
    check("wp_err_pulse", {7'd0, wprot_err}, {7'd0, c_prot});
    read_check("wp_rd_cell", 6'h0A, c_prot ? 4'hA : 4'h5);
    step();
    check("wp_err_end", {7'd0, wprot_err}, 8'd0);

    // Asynchronous reset mid-RUN after a store.
    cpu_addr = 6'h2A;
    #2;
    rst_p = 1'b1;
    #1;
    check("arst_hold", {7'd0, cpu_hold}, 8'd1);
    check("arst_ready", {7'd0, ld_ready}, 8'd1);
    check("arst_done", {7'd0, ld_done}, 8'd0);
    check("arst_data", {4'h0, cpu_data}, 8'h0);
    rst_p = 1'b0;
    step();
    // Valid and skip together: the nibble lands at pointer 0, then RUN.
    ld_valid = 1'b1;
    ld_skip  = 1'b1;
    ld_data  = 4'hE;
    step();
    ld_valid = 1'b0;
    ld_skip  = 1'b0;
    check("vs_done", {7'd0, ld_done}, 8'd1);
    read_check("arst_rd00", 6'h00, 4'hE);
    read_check("arst_rd2a", 6'h2A, 4'h0);
    read_check("arst_rd01", 6'h01, 4'h0);

    // Toggling valid, skip on the 10th accept: cell k = k+3.
    pulse_reset();
    step();
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
      ld_valid = ((cyc % 2) == 0);
      ld_data  = 4'(k + 3);
      ld_skip  = ld_valid && (k == 9);
      step();
      if (ld_valid) k++;
    end
    ld_valid = 1'b0;
    ld_skip  = 1'b0;
    check("tg_done", {7'd0, ld_done}, 8'd1);
    read_check("tg_rd00", 6'h00, 4'h3);
    read_check("tg_rd01", 6'h01, 4'h4);
    read_check("tg_rd09", 6'h09, 4'hC);
    read_check("tg_rd0a", 6'h0A, 4'h0);
    read_check("tg_rd3f", 6'h3F, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu4_nibble_ram.md
# cpu4_nibble_ram

Program/data memory for the 4-bit accumulator CPU. It holds 64 × 4-bit cells and returns read data combinationally to the CPU's `data_in` within the cycle the CPU drives the address. It also snoops the two nibbles returned before a store to recover the store address, because the CPU bus carries write data rather than an address during a write cycle. A sequential loader port fills the memory after reset while holding the CPU in reset.

## Interface
Parameters:
- `DEPTH`, 64: number of cells; fixed at 64 because addresses are 6 bits.
- `WPROT_TOP`, 31: highest protected address when `CPU4_RAM_WPROT_EN` is defined.

Ports:
- `clk`  in  1: clock.
- `rst_p`  in  1: reset, asynchronous, active-high.
- `cpu_addr`  in  6: CPU `io_out[5:0]`. This is the address, or the write data on bits [3:0] when `cpu_wcyc` is high.
- `cpu_wcyc`  in  1: CPU `io_out[6]`, the write-cycle strobe.
- `cpu_data`  out  4: connects to CPU `data_in`.
- `cpu_hold`  out  1: holds the CPU in reset. The wrapper ORs it into the CPU's `rst_p`.
- `ld_valid`  in  1: loader nibble valid.
- `ld_data`  in  4: loader nibble.
- `ld_skip`  in  1: ends loading early.
- `ld_ready`  out  1: loader can accept a nibble.
- `ld_done`  out  1: loading is complete and the CPU is running.
- `wprot_err`  out  1: one-cycle pulse when a store is dropped by write protection.

## Operation
- Two states, LOAD and RUN. Reset enters LOAD.
- Reset values:
  - all cells = 0
  - `ptr` = 0
  - history `h_hi`, `h_lo` = 0
  - `ld_ready` = 1, `cpu_hold` = 1, `ld_done` = 0, `wprot_err` = 0, `cpu_data` = 0
- LOAD state:
  - `ld_ready` = 1, `cpu_hold` = 1, `cpu_data` = 0.
  - A transfer happens on any edge with `ld_valid` high: `mem[ptr] <= ld_data` and `ptr <= ptr + 1`.
  - Accepting the nibble at `ptr` = 63 moves to RUN; `ptr` wraps to 0.
  - `ld_skip` high moves to RUN at the next edge. Cells not yet loaded keep 0.
  - If `ld_valid` and `ld_skip` are both high on the same edge, the nibble is written first, then the block moves to RUN.
  - `cpu_addr` and `cpu_wcyc` are ignored in LOAD.
- RUN state:
  - `ld_ready` = 0, `cpu_hold` = 0, `ld_done` = 1. Loader inputs are ignored.
  - RUN is left only by `rst_p`.
- Reads in RUN: when `cpu_wcyc` = 0, `cpu_data` = `mem[cpu_addr]` (purely combinational). When `cpu_wcyc` = 1, `cpu_data` = 0.
- Snoop in RUN: on each edge with `cpu_wcyc` = 0, `h_hi <= h_lo` and `h_lo <= cpu_data`. The history is frozen during write cycles.
- Store in RUN: on an edge with `cpu_wcyc` = 1, `mem[{h_hi[1:0], h_lo}] <= cpu_addr[3:0]`.
- Back-to-back `cpu_wcyc` cycles reuse the same frozen address; the last data wins.

## Timing
- Read latency is zero cycles, combinational from `cpu_addr` to `cpu_data`.
- Writes commit at the clock edge and are visible to a read in the following cycle.
- A loaded nibble is readable from the cycle after its accepting edge.
- Minimum load time is 64 cycles with `ld_valid` held high. `ld_done` and the release of `cpu_hold` appear in the cycle after the 64th accept.
- `cpu_hold` falls at the same edge that `ld_done` rises.
- `wprot_err` is registered: it is high for exactly the one cycle after the dropped store edge.
- `rst_p` asserted mid-load or mid-run has an immediate asynchronous effect:
  - all cells and the history clear
  - state returns to LOAD and `ptr` = 0
  - `cpu_hold` = 1

## Configuration
- `CPU4_RAM_WPROT_EN` defined: RUN-state stores to addresses 0..`WPROT_TOP` are dropped, the memory is unchanged, and `wprot_err` pulses. Loader writes are never protected.
- `CPU4_RAM_WPROT_EN` undefined: all addresses are writable and `wprot_err` is tied to 0.

## Test plan
- Reset → `ld_ready` = 1, `cpu_hold` = 1, `ld_done` = 0, `cpu_data` = 0. Any read after a skip-load returns 0.
- Load nibble i[3:0] for i = 0..63 with `ld_valid` held → after 64 edges `ld_done` = 1 and `cpu_hold` = 0. Then `cpu_addr` = 0x25 → `cpu_data` = 0x5, and `cpu_addr` = 0x3F → 0xF.
- Load with `ld_valid` toggling 1,0,1,0 → the cell count advances only on valid cycles. Assert `ld_skip` with `ld_valid` on the 10th accept → cells 0..9 are loaded, cells 10..63 read 0, RUN is entered.
- In RUN:
  - read cells returning 0x2 then 0xA on consecutive cycles
  - then drive `cpu_wcyc` = 1 with `cpu_addr` = 0x07 → next cycle, read of 0x2A returns 0x7
  - a second consecutive write cycle with data 0x9 → 0x2A reads 0x9
- Snoop address 0x0A with `CPU4_RAM_WPROT_EN` defined → the cell is unchanged and `wprot_err` = 1 for exactly one cycle. Without the macro → the cell is written and `wprot_err` stays 0.
- Assert `rst_p` during RUN after a store → the cell is 0, state is LOAD, `ptr` = 0, `cpu_hold` = 1.
